pipe_stage_reg: RTL and testbench

- Generic inter-stage pipeline register for the pipelined CPU: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries one opaque data bundle plus one control bundle, each of parametrised width.
- Adds valid/ready handshaking, stall (back-pressure) and flush (bubble insertion).
- Control outputs are forced to a safe NOP pattern whenever the stage holds a bubble, so RegWrite, MemWrite and branch signals can never fire from an invalid slot.

---
 rtl/cpu_pipe_pkg.sv | 57 +++++
 rtl/n_dff.sv | 23 ++
 rtl/pipe_skid_buf.sv | 52 +++++
 rtl/pipe_stage_reg.sv | 120 ++++++++++++
 tb/tb_pipe_stage_reg.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline stage registers: default bundle
// widths, per-stage control bundle layouts and their bubble (NOP) patterns.
// Every NOP constant deasserts all side-effecting controls, so a stage that
// presents a bubble can never write a register, write memory or branch.
package cpu_pipe_pkg;

    localparam int PIPE_DATA_W = 64;
    localparam int PIPE_CTRL_W = 16;

    typedef struct packed {
        logic pred_taken;
        logic fetch_fault;
    } if_id_ctrl_t;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       jump;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic [1:0] mem_size;
        logic       reg_write;
        logic       mem_to_reg;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } mem_wb_ctrl_t;

    localparam int IF_ID_CTRL_W  = $bits(if_id_ctrl_t);
    localparam int ID_EX_CTRL_W  = $bits(id_ex_ctrl_t);
    localparam int EX_MEM_CTRL_W = $bits(ex_mem_ctrl_t);
    localparam int MEM_WB_CTRL_W = $bits(mem_wb_ctrl_t);

    localparam if_id_ctrl_t  IF_ID_CTRL_NOP  = '0;
    localparam id_ex_ctrl_t  ID_EX_CTRL_NOP  = '0;
    localparam ex_mem_ctrl_t EX_MEM_CTRL_NOP = '0;
    localparam mem_wb_ctrl_t MEM_WB_CTRL_NOP = '0;

    // Zero-extend a stage's control struct into a generic ctrl bus.
    function automatic logic [PIPE_CTRL_W-1:0] pack_id_ex_ctrl(input id_ex_ctrl_t c);
        logic [PIPE_CTRL_W-1:0] r;
        r = '0;
        r[ID_EX_CTRL_W-1:0] = c;
        return r;
    endfunction

endpackage

// File: rtl/n_dff.sv
// n_dff: W-bit D flip-flop cell with synchronous active-high reset to RST_VAL
// and a load-enable mux (q holds when en=0).
module n_dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Reset wins, otherwise load d only when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RST_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: single-entry holding register with a valid bit. Catches the
// beat accepted while the main stage register is stalled. Used by
// pipe_stage_reg only when PIPE_STAGE_REG_SKID_EN is defined.
module pipe_skid_buf
    import cpu_pipe_pkg::*;
#(
    parameter int                DATA_W   = PIPE_DATA_W,
    parameter int                CTRL_W   = PIPE_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_unload,
    input  logic [DATA_W-1:0] i_data,
    input  logic [CTRL_W-1:0] i_ctrl,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CTRL_W-1:0] o_ctrl
);

    logic w_valid_nxt;
    logic w_load_en;

    // Clear beats load, load beats unload; otherwise the entry holds.
    always_comb begin
        w_valid_nxt = o_valid;
        if (i_clear) begin
            w_valid_nxt = 1'b0;
        end else if (i_load) begin
            w_valid_nxt = 1'b1;
        end else if (i_unload) begin
            w_valid_nxt = 1'b0;
        end
    end

    assign w_load_en = i_load & ~i_clear;

    n_dff #(.W(1), .RST_VAL(1'b0)) u_valid (
        .clk(clk), .reset(reset), .en(1'b1), .d(w_valid_nxt), .q(o_valid)
    );

    n_dff #(.W(DATA_W), .RST_VAL('0)) u_data (
        .clk(clk), .reset(reset), .en(w_load_en), .d(i_data), .q(o_data)
    );

    n_dff #(.W(CTRL_W), .RST_VAL(CTRL_NOP)) u_ctrl (
        .clk(clk), .reset(reset), .en(w_load_en), .d(i_ctrl), .q(o_ctrl)
    );

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage pipeline register (IF/ID, ID/EX,
// EX/MEM, MEM/WB) with valid/ready handshake, stall and flush.
// out_ctrl is masked to CTRL_NOP whenever the slot holds a bubble.
// Build option PIPE_STAGE_REG_SKID_EN adds a one-entry skid buffer so that
// in_ready comes straight from a flop (no out_ready -> in_ready path).
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int                DATA_W   = PIPE_DATA_W,
    parameter int                CTRL_W   = PIPE_CTRL_W,
    parameter logic [CTRL_W-1:0] CTRL_NOP = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    logic              w_main_free;
    logic              w_accept;
    logic              w_main_load;
    logic              w_main_en;
    logic              w_valid_nxt;
    logic [DATA_W-1:0] w_main_d;
    logic [CTRL_W-1:0] w_main_c;

    assign w_main_free = ~r_valid | out_ready;
    assign w_accept    = in_valid & in_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
    logic              w_skid_valid;
    logic [DATA_W-1:0] w_skid_data;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic              w_skid_load;
    logic              w_skid_unload;

    // Accepting only while the skid is empty keeps the two entries FIFO:
    // the main register always holds the older beat.
    assign in_ready      = ~w_skid_valid;
    assign w_skid_load   = w_accept & ~w_main_free;
    assign w_skid_unload = w_skid_valid & w_main_free;

    pipe_skid_buf #(
        .DATA_W(DATA_W), .CTRL_W(CTRL_W), .CTRL_NOP(CTRL_NOP)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (flush),
        .i_load   (w_skid_load),
        .i_unload (w_skid_unload),
        .i_data   (in_data),
        .i_ctrl   (in_ctrl),
        .o_valid  (w_skid_valid),
        .o_data   (w_skid_data),
        .o_ctrl   (w_skid_ctrl)
    );

    // Main register source: the skid beat drains first, else the input beat.
    always_comb begin
        w_main_load = 1'b0;
        w_main_d    = in_data;
        w_main_c    = in_ctrl;
        if (w_skid_unload) begin
            w_main_load = 1'b1;
            w_main_d    = w_skid_data;
            w_main_c    = w_skid_ctrl;
        end else if (w_accept & w_main_free) begin
            w_main_load = 1'b1;
        end
    end
`else
    assign in_ready    = w_main_free;
    assign w_main_load = w_accept;
    assign w_main_d    = in_data;
    assign w_main_c    = in_ctrl;
`endif

    // Next valid: flush kills, a load fills, a completed output empties.
    always_comb begin
        w_valid_nxt = r_valid;
        if (flush) begin
            w_valid_nxt = 1'b0;
        end else if (w_main_load) begin
            w_valid_nxt = 1'b1;
        end else if (out_ready) begin
            w_valid_nxt = 1'b0;
        end
    end

    // A flushed beat is never loaded, so out_data keeps its last value.
    assign w_main_en = w_main_load & ~flush;

    n_dff #(.W(1), .RST_VAL(1'b0)) u_valid (
        .clk(clk), .reset(reset), .en(1'b1), .d(w_valid_nxt), .q(r_valid)
    );

    n_dff #(.W(DATA_W), .RST_VAL('0)) u_data (
        .clk(clk), .reset(reset), .en(w_main_en), .d(w_main_d), .q(r_data)
    );

    n_dff #(.W(CTRL_W), .RST_VAL(CTRL_NOP)) u_ctrl (
        .clk(clk), .reset(reset), .en(w_main_en), .d(w_main_c), .q(r_ctrl)
    );

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_ctrl  = r_valid ? r_ctrl : CTRL_NOP;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: table vectors, directed stall/flush/skid
// sequences, and random traffic against a queue-based reference model.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_REG_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam logic [15:0] NOP = 16'h0000;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
    logic [63:0] in_data, out_data;
    logic [15:0] in_ctrl, out_ctrl;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ctrl(out_ctrl)
    );

    typedef struct packed {
        logic [63:0] d;
        logic [15:0] c;
    } beat_t;

    typedef struct {
        logic rst, iv;
        logic [63:0] d;
        logic [15:0] c;
        logic fl, ordy;
        logic ev, chk_d;
        logic [63:0] ed;
        logic [15:0] ec;
        logic er;
    } vec_t;

    beat_t       mq[$];
    bit          model_live = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        obs_valid, obs_ready;
    logic [63:0] obs_data;
    logic [15:0] obs_ctrl;
    vec_t        tbl[10];
    logic [63:0] got[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive, sample before the edge, check vs model, advance model.
    task automatic step(input logic rst, input logic iv, input logic [63:0] d,
                        input logic [15:0] c, input logic fl, input logic ordy);
        bit ev, er;
        @(negedge clk);
        reset = rst; in_valid = iv; in_data = d; in_ctrl = c;
        flush = fl; out_ready = ordy;
        #1;
        obs_valid = out_valid; obs_ready = in_ready;
        obs_data = out_data;   obs_ctrl = out_ctrl;
        ev = (mq.size() > 0);
        er = SKID ? (mq.size() < 2) : (mq.size() == 0 || ordy);
        if (model_live) begin
            chk("model_out_valid", {63'd0, obs_valid}, {63'd0, ev});
            chk("model_in_ready", {63'd0, obs_ready}, {63'd0, er});
            chk("model_out_ctrl", {48'd0, obs_ctrl}, {48'd0, ev ? mq[0].c : NOP});
            if (ev) chk("model_out_data", obs_data, mq[0].d);
        end
        @(posedge clk);
        if (rst || fl) begin
            mq.delete();
        end else begin
            if (ev && ordy) void'(mq.pop_front());
            if (iv && er) mq.push_back('{d: d, c: c});
        end
        if (rst) model_live = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0;
        flush = 1'b0; out_ready = 1'b1;

        //        rst   iv    d        c         fl    ordy  ev    chk_d ed      ec        er
        tbl[0] = '{1'b1, 1'b1, 64'h99, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 16'h0000, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 64'h1,  16'h0011, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 16'h0000, 1'b1};
        tbl[2] = '{1'b0, 1'b1, 64'h2,  16'h0012, 1'b0, 1'b1, 1'b1, 1'b1, 64'h1, 16'h0011, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 64'h3,  16'h0013, 1'b0, 1'b1, 1'b1, 1'b1, 64'h2, 16'h0012, 1'b1};
        tbl[4] = '{1'b0, 1'b1, 64'h4,  16'h0014, 1'b0, 1'b1, 1'b1, 1'b1, 64'h3, 16'h0013, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 64'hEE, 16'h00FF, 1'b0, 1'b1, 1'b1, 1'b1, 64'h4, 16'h0014, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 64'hEE, 16'h00FF, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 16'h0000, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 64'hEE, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 16'h0000, 1'b1};
        tbl[8] = '{1'b0, 1'b1, 64'h5,  16'h0015, 1'b1, 1'b1, 1'b0, 1'b0, 64'h0, 16'h0000, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 64'hEE, 16'h00FF, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 16'h0000, 1'b1};

        // Reset cycle 1 of 2 (table row 0 is the second).
        step(1'b1, 1'b1, 64'h99, 16'hFFFF, 1'b0, 1'b1);
        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].c, tbl[i].fl, tbl[i].ordy);
            chk("tbl_out_valid", {63'd0, obs_valid}, {63'd0, tbl[i].ev});
            chk("tbl_out_ctrl", {48'd0, obs_ctrl}, {48'd0, tbl[i].ec});
            chk("tbl_in_ready", {63'd0, obs_ready}, {63'd0, tbl[i].er});
            if (tbl[i].chk_d) chk("tbl_out_data", obs_data, tbl[i].ed);
        end

        // Stall: A5 held for 5 cycles while B6 waits upstream.
        step(1'b1, 1'b0, 64'h0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 64'hA5, 16'h00A5, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 64'hB6, 16'h00B6, 1'b0, 1'b0);
            chk("stall_data", obs_data, 64'hA5);
            chk("stall_valid", {63'd0, obs_valid}, 64'd1);
            if (!SKID || k > 0) chk("stall_in_ready", {63'd0, obs_ready}, 64'd0);
        end
        step(1'b0, 1'b1, 64'hB6, 16'h00B6, 1'b0, 1'b1);
        chk("stall_release_data", obs_data, 64'hA5);
        step(1'b0, 1'b0, 64'h0, 16'h0, 1'b0, 1'b1);
        chk("stall_b6_valid", {63'd0, obs_valid}, 64'd1);
        chk("stall_b6_data", obs_data, 64'hB6);
        step(1'b0, 1'b0, 64'h0, 16'h0, 1'b0, 1'b1);
        chk("stall_drained", {63'd0, obs_valid}, 64'd0);

        // Flush with 7 undelivered (stalled) and 8 offered.
        step(1'b1, 1'b0, 64'h0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 64'h7, 16'h0007, 1'b0, 1'b1);
        step(1'b0, 1'b1, 64'h8, 16'h0008, 1'b1, 1'b0);
        chk("flush_hold7", obs_data, 64'h7);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 64'h0, 16'h00FF, 1'b0, 1'b1);
            chk("flush_a_valid", {63'd0, obs_valid}, 64'd0);
            chk("flush_a_ctrl", {48'd0, obs_ctrl}, {48'd0, NOP});
        end
        // Flush while 7 is delivered and 8 is accepted in the same cycle.
        step(1'b0, 1'b1, 64'h7, 16'h0007, 1'b0, 1'b1);
        step(1'b0, 1'b1, 64'h8, 16'h0008, 1'b1, 1'b1);
        chk("flush_b_deliver7", obs_data, 64'h7);
        chk("flush_b_accept8", {63'd0, obs_ready}, 64'd1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 64'h0, 16'h00FF, 1'b0, 1'b1);
            chk("flush_b_valid", {63'd0, obs_valid}, 64'd0);
            chk("flush_b_ctrl", {48'd0, obs_ctrl}, {48'd0, NOP});
        end

        // Ordering through a stall that lands 2 in the skid entry.
        begin
            logic ordy_pat[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                                   1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
            int idx = 0;
            step(1'b1, 1'b0, 64'h0, 16'h0, 1'b0, 1'b1);
            got.delete();
            for (int cyc = 0; cyc < 12; cyc++) begin
                step(1'b0, idx < 3, 64'(idx + 1), 16'(idx + 16'h40), 1'b0, ordy_pat[cyc]);
                if (SKID && cyc == 2) chk("skid_in_ready_drop", {63'd0, obs_ready}, 64'd0);
                if (obs_valid && ordy_pat[cyc]) got.push_back(obs_data);
                if (idx < 3 && obs_ready) idx++;
            end
            chk("order_count", 64'(got.size()), 64'd3);
            for (int k = 0; k < 3; k++)
                if (k < got.size()) chk("order_value", got[k], 64'(k + 1));
        end

        // Random traffic against the model.
        for (int k = 0; k < 500; k++) begin
            step($urandom_range(63) == 0, $urandom_range(3) != 0,
                 {$urandom, $urandom}, 16'($urandom),
                 $urandom_range(15) == 0, $urandom_range(3) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
